// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcode, state and control-encoding definitions for the RV32I control sequencer
package rv32i_pkg;

    // Base opcodes (IR[6:0]); also consumed by the immediate generator.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_OPIMM,
        CL_OP,
        CL_FENCE,
        CL_SYSTEM,
        CL_ILLEGAL
    } opclass_t;

    localparam logic [1:0] PC_PLUS4   = 2'd0;
    localparam logic [1:0] PC_IMM     = 2'd1;
    localparam logic [1:0] PC_ALU     = 2'd2;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_LOAD    = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;
    localparam logic [1:0] WB_IMM     = 2'd3;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_RTYPE  = 2'd1;
    localparam logic [1:0] ALU_ITYPE  = 2'd2;
    localparam logic [1:0] ALU_CMP    = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ECALL   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// rtl/rv32i_ctrl_fsm_if.sv - handshake and datapath-control bundle between the sequencer and the core
// master: the control sequencer (drives requests, strobes, selects, trap status)
// slave:  the datapath / memories (drive ready, IR fields, branch result)
interface rv32i_ctrl_fsm_if;
    logic       imem_req;
    logic       imem_ready;
    logic [6:0] ir_opcode;
    logic [2:0] ir_funct3;
    logic       ir_sys_zero;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_mode;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  imem_ready, ir_opcode, ir_funct3, ir_sys_zero, branch_taken, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               alu_mode, rf_we, wb_sel, retire, trap, trap_cause
    );

    modport slave (
        output imem_ready, ir_opcode, ir_funct3, ir_sys_zero, branch_taken, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               alu_mode, rf_we, wb_sel, retire, trap, trap_cause
    );
endinterface

// File: rtl/rv32i_opclass_dec.sv
// rtl/rv32i_opclass_dec.sv - combinational opcode to instruction-class decoder
// opcode in  7  IR[6:0]
// cls    out    instruction class
// legal  out 1  opcode is one of the RV32I base opcodes (SYSTEM counts as legal)
module rv32i_opclass_dec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       legal
);

    always_comb begin
        legal = 1'b1;
        cls   = CL_ILLEGAL;
        unique case (opcode)
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_OPIMM:  cls = CL_OPIMM;
            OPC_OP:     cls = CL_OP;
            OPC_FENCE:  cls = CL_FENCE;
            OPC_SYSTEM: cls = CL_SYSTEM;
            default: begin
                cls   = CL_ILLEGAL;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// rtl/rv32i_ctrl_fsm.sv - multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb/trap)
// clk, rst  core clock, synchronous active-high reset
// bus       master side of rv32i_ctrl_fsm_if: imem/dmem handshakes, IR fields,
//           datapath strobes and selects, retire pulse and trap status
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    rv32i_ctrl_fsm_if.master   bus
);

    localparam int TO_W  = $clog2(MEM_TIMEOUT + 1);
    // Keep at least one bit so MEM_TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] to_cnt;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic [1:0]       cause_nx;
    opclass_t         cls;
    logic             legal;
    logic             waiting;
    logic             timed_out;

    // SYSTEM is trapped as a whole, so funct3 and the ECALL/EBREAK hint
    // never influence sequencing.
    logic unused_ir_fields;
    assign unused_ir_fields = ^{bus.ir_funct3, bus.ir_sys_zero};

    rv32i_opclass_dec u_dec (
        .opcode (bus.ir_opcode),
        .cls    (cls),
        .legal  (legal)
    );

    assign waiting   = ((state == ST_FETCH) && !bus.imem_ready) ||
                       ((state == ST_MEM)   && !bus.dmem_ready);
    // A ready seen in the same cycle the limit is reached wins over the trap.
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && (to_cnt == TO_LIMIT);

    always_comb begin
        state_nx = state;
        cause_nx = cause_q;
        case (state)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    state_nx = ST_DECODE;
                end else if (timed_out) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else if (cls == CL_SYSTEM) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_ECALL;
                end else if (cls == CL_FENCE) begin
                    state_nx = ST_WB;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls == CL_BRANCH)                         state_nx = ST_FETCH;
                else if (cls == CL_LOAD || cls == CL_STORE)   state_nx = ST_MEM;
                else                                          state_nx = ST_WB;
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    state_nx = (cls == CL_STORE) ? ST_FETCH : ST_WB;
                end else if (timed_out) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_WB:   state_nx = ST_FETCH;
            ST_TRAP: state_nx = ST_TRAP;
            default: state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            to_cnt  <= '0;
        end else begin
            state   <= state_nx;
            trap_q  <= (state_nx == ST_TRAP);
            cause_q <= cause_nx;
            // Any state change clears the counter, which covers entry to FETCH and MEM.
            if (state_nx != state)
                to_cnt <= '0;
            else if (waiting && (MEM_TIMEOUT != 0))
                to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Strobes are gated by rst so nothing is issued while reset is applied.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = PC_PLUS4;
        bus.alu_a_sel = 1'b0;
        bus.alu_b_sel = 1'b0;
        bus.alu_mode  = ALU_ADD;
        bus.rf_we     = 1'b0;
        bus.wb_sel    = WB_ALU;
        bus.retire    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ready;
                end
                ST_EXEC: begin
                    case (cls)
                        CL_OP:    bus.alu_mode = ALU_RTYPE;
                        CL_OPIMM: begin
                            bus.alu_mode  = ALU_ITYPE;
                            bus.alu_b_sel = 1'b1;
                        end
                        CL_LOAD, CL_STORE, CL_JALR: bus.alu_b_sel = 1'b1;
                        CL_AUIPC: begin
                            bus.alu_a_sel = 1'b1;
                            bus.alu_b_sel = 1'b1;
                        end
                        CL_BRANCH: begin
                            bus.alu_mode = ALU_CMP;
                            bus.pc_we    = 1'b1;
                            bus.pc_sel   = bus.branch_taken ? PC_IMM : PC_PLUS4;
                            bus.retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (cls == CL_STORE);
                    if (bus.dmem_ready && (cls == CL_STORE)) begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                    end
                end
                ST_WB: begin
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                    case (cls)
                        CL_OP, CL_OPIMM, CL_AUIPC: bus.rf_we = 1'b1;
                        CL_LUI: begin
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_IMM;
                        end
                        CL_LOAD: begin
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_LOAD;
                        end
                        CL_JAL: begin
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_PC4;
                            bus.pc_sel = PC_IMM;
                        end
                        CL_JALR: begin
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_PC4;
                            bus.pc_sel = PC_ALU;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// tb/tb_rv32i_ctrl_fsm.sv - self-checking bench for rv32i_ctrl_fsm with an instruction-level reference model
module tb_rv32i_ctrl_fsm;
    import rv32i_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_ctrl_fsm_if bus ();

    rv32i_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Observed output vector, bit layout:
    // 17 imem_req 16 dmem_req 15 dmem_we 14 ir_we 13 pc_we 12:11 pc_sel 10 alu_a 9 alu_b
    // 8:7 alu_mode 6 rf_we 5:4 wb_sel 3 retire 2 trap 1:0 trap_cause
    logic [17:0] obs;
    assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_sel,
                  bus.alu_a_sel, bus.alu_b_sel, bus.alu_mode, bus.rf_we, bus.wb_sel,
                  bus.retire, bus.trap, bus.trap_cause};

    localparam logic [17:0] IMR = 18'h1 << 17;
    localparam logic [17:0] DMR = 18'h1 << 16;
    localparam logic [17:0] DWE = 18'h1 << 15;
    localparam logic [17:0] IRW = 18'h1 << 14;
    localparam logic [17:0] PCW = 18'h1 << 13;
    localparam logic [17:0] AAS = 18'h1 << 10;
    localparam logic [17:0] ABS = 18'h1 << 9;
    localparam logic [17:0] RFW = 18'h1 << 6;
    localparam logic [17:0] RET = 18'h1 << 3;
    localparam logic [17:0] TRP = 18'h1 << 2;

    function automatic logic [17:0] f_pcs(input int v); return 18'(v) << 11; endfunction
    function automatic logic [17:0] f_am(input int v);  return 18'(v) << 7;  endfunction
    function automatic logic [17:0] f_wb(input int v);  return 18'(v) << 4;  endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge.
    task automatic cyc(input string tag, input bit ir_rdy, input bit dr_rdy, input logic [17:0] exp);
        bus.imem_ready = ir_rdy;
        bus.dmem_ready = dr_rdy;
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                          OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
    endfunction

    function automatic logic [17:0] exp_exec(input logic [6:0] op, input bit bt);
        case (op)
            OPC_OP:               return f_am(1);
            OPC_OPIMM:            return f_am(2) | ABS;
            OPC_LOAD, OPC_STORE:  return ABS;
            OPC_JALR:             return ABS;
            OPC_AUIPC:            return AAS | ABS;
            OPC_BRANCH:           return f_am(3) | PCW | f_pcs(bt ? 1 : 0) | RET;
            default:              return 18'h0;
        endcase
    endfunction

    function automatic logic [17:0] exp_wb(input logic [6:0] op);
        case (op)
            OPC_OP, OPC_OPIMM, OPC_AUIPC: return PCW | RET | RFW;
            OPC_LUI:   return PCW | RET | RFW | f_wb(3);
            OPC_LOAD:  return PCW | RET | RFW | f_wb(1);
            OPC_JAL:   return PCW | RET | RFW | f_wb(2) | f_pcs(1);
            OPC_JALR:  return PCW | RET | RFW | f_wb(2) | f_pcs(2);
            default:   return PCW | RET;
        endcase
    endfunction

    task automatic trap_hold(input int cause, input int n);
        for (int i = 0; i < n; i++) begin
            bus.branch_taken = 1'($urandom);
            cyc($sformatf("trap%0d", cause), 1'($urandom), 1'($urandom), TRP | 18'(cause));
        end
    endtask

    // Request held for 'waits' cycles then ready; more than TMO waits times out.
    task automatic access(input string tag, input bit is_i, input bit we, input int waits,
                          input logic [17:0] on_rdy, output bit to);
        logic [17:0] base;
        bit rdy;
        base = is_i ? IMR : (DMR | (we ? DWE : 18'h0));
        to = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i > TMO) begin
                to = 1'b1;
                break;
            end
            rdy = (i == waits);
            cyc($sformatf("%s[%0d]", tag, i), is_i && rdy, !is_i && rdy, base | (rdy ? on_rdy : 18'h0));
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input bit bt,
                             output bit trapped);
        bit to;
        trapped = 1'b0;
        bus.ir_opcode    = op;
        bus.ir_funct3    = 3'($urandom);
        bus.ir_sys_zero  = 1'($urandom);
        bus.branch_taken = bt;
        access($sformatf("fetch op%02h", op), 1'b1, 1'b0, wi, IRW, to);
        if (to) begin
            trap_hold(3, 20);
            trapped = 1'b1;
            return;
        end
        cyc($sformatf("decode op%02h", op), 1'b0, 1'b0, 18'h0);
        if (!is_legal(op)) begin
            trap_hold(1, 20);
            trapped = 1'b1;
            return;
        end
        if (op == OPC_SYSTEM) begin
            trap_hold(2, 20);
            trapped = 1'b1;
            return;
        end
        if (op == OPC_FENCE) begin
            cyc("wb fence", 1'b0, 1'b0, exp_wb(op));
            return;
        end
        cyc($sformatf("exec op%02h", op), 1'b0, 1'b0, exp_exec(op, bt));
        if (op == OPC_BRANCH) return;
        if (op == OPC_LOAD || op == OPC_STORE) begin
            access($sformatf("mem op%02h", op), 1'b0, op == OPC_STORE, wd,
                   (op == OPC_STORE) ? (PCW | RET) : 18'h0, to);
            if (to) begin
                trap_hold(3, 20);
                trapped = 1'b1;
                return;
            end
            if (op == OPC_STORE) return;
        end
        cyc($sformatf("wb op%02h", op), 1'b0, 1'b0, exp_wb(op));
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 19) == 0) return TMO + 1 + $urandom_range(0, 2);
        return $urandom_range(0, TMO);
    endfunction

    logic [6:0] legal_ops [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                   OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE};

    initial begin
        bit t;
        logic [6:0] op;
        int r;
        bus.imem_ready   = 1'b0;
        bus.dmem_ready   = 1'b0;
        bus.ir_opcode    = 7'h0;
        bus.ir_funct3    = 3'h0;
        bus.ir_sys_zero  = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        do_reset();

        // ADDI with zero-wait fetch, then LW with 3 dmem wait cycles.
        run_instr(OPC_OPIMM, 0, 0, 1'b0, t);
        run_instr(OPC_LOAD, 0, 3, 1'b0, t);
        run_instr(OPC_BRANCH, 0, 0, 1'b1, t);
        run_instr(OPC_BRANCH, 0, 0, 1'b0, t);

        // Illegal opcode and ECALL, each after reset.
        do_reset();
        run_instr(7'h7f, 0, 0, 1'b0, t);
        do_reset();
        bus.ir_sys_zero = 1'b1;
        run_instr(OPC_SYSTEM, 0, 0, 1'b0, t);
        do_reset();

        // Fetch timeout, then ready exactly at the limit, then a dmem timeout.
        run_instr(OPC_OP, TMO + 1, 0, 1'b0, t);
        do_reset();
        run_instr(OPC_OP, TMO, 0, 1'b0, t);
        run_instr(OPC_STORE, 0, TMO, 1'b0, t);
        run_instr(OPC_LOAD, 0, TMO + 1, 1'b0, t);
        do_reset();

        // Reset pulsed while a store waits on dmem_ready.
        bus.ir_opcode = OPC_STORE;
        access("rs fetch", 1'b1, 1'b0, 0, IRW, t);
        cyc("rs decode", 1'b0, 1'b0, 18'h0);
        cyc("rs exec", 1'b0, 1'b0, ABS);
        cyc("rs mem0", 1'b0, 1'b0, DMR | DWE);
        cyc("rs mem1", 1'b0, 1'b0, DMR | DWE);
        bus.dmem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(OPC_OP, $urandom_range(0, TMO), 0, 1'b0, t);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                do op = 7'($urandom); while (is_legal(op));
            end else if (r < 10) begin
                op = OPC_SYSTEM;
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
            end
            run_instr(op, rand_wait(), rand_wait(), 1'($urandom), t);
            if (t) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
